// File: rtl/lc3_mem_ctrl.sv
// LC3 data-memory sequencer: arbitrates IF/D, drives MAR/Dataram, REQ-to-ACK 2 cycles direct, 3 indirect.
// Requesters hold REQ until their ACK; `ARB_RR_EN selects round-robin instead of fixed D-over-IF priority.
module lc3_mem_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_ACK,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic              D_IND,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_ACK,
  output logic [DATA_W-1:0] RDATA,
  output logic              BUSY,
  output logic              MAR_LE,
  output logic              MAR_CONTROL,
  output logic [ADDR_W-1:0] Y,
  output logic              RAM_WE,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    IND    = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic              is_d;
    logic              we;
    logic              ind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state;
  req_t              lat;
  req_t              nxt_req;
  logic              any_req;
  logic              grant_d;
  logic [DATA_W-1:0] rdata_q;

  assign any_req = D_REQ | IF_REQ;

`ifdef ARB_RR_EN
  // last_grant_d = 0 means IF was granted last; on a collision the other side wins.
  logic last_grant_d;

  assign grant_d = D_REQ && (!IF_REQ || !last_grant_d);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_grant_d <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_grant_d <= grant_d;
    end
  end
`else
  assign grant_d = D_REQ;
`endif

  // IF is always a direct read, so its type fields are forced to zero.
  always_comb begin
    nxt_req       = '0;
    nxt_req.is_d  = grant_d;
    nxt_req.we    = grant_d & D_WE;
    nxt_req.ind   = grant_d & D_IND;
    nxt_req.addr  = grant_d ? D_ADDR : IF_ADDR;
    nxt_req.wdata = grant_d ? D_WDATA : '0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      lat     <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            lat   <= nxt_req;
            state <= nxt_req.ind ? IND : ACCESS;
          end
        end
        IND: state <= ACCESS;
        ACCESS: begin
          if (!lat.we) begin
            rdata_q <= RAM_RDATA;
          end
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode from state so an asynchronous reset drops them without a clock edge.
  assign BUSY        = (state != IDLE);
  assign MAR_LE      = (state == IDLE && any_req) || (state == IND && lat.ind);
  assign MAR_CONTROL = (state == IND) && lat.ind;
  assign Y           = (state == IDLE) ? nxt_req.addr : lat.addr;
  assign RAM_WE      = (state == ACCESS) && lat.we;
  assign RAM_WDATA   = lat.wdata;
  assign D_ACK       = (state == DONE) && lat.is_d;
  assign IF_ACK      = (state == DONE) && !lat.is_d;
  assign RDATA       = rdata_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Bench for lc3_mem_ctrl: MAR + Dataram model around the DUT, transaction-level reference memory.
module tb_lc3_mem_ctrl;
  localparam logic [15:0] WIN = 16'h0100;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IF_REQ = 1'b0;
  logic [15:0] IF_ADDR = '0;
  logic        IF_ACK;
  logic        D_REQ = 1'b0;
  logic        D_WE = 1'b0;
  logic        D_IND = 1'b0;
  logic [15:0] D_ADDR = '0;
  logic [15:0] D_WDATA = '0;
  logic        D_ACK;
  logic [15:0] RDATA;
  logic        BUSY;
  logic        MAR_LE;
  logic        MAR_CONTROL;
  logic [15:0] Y;
  logic        RAM_WE;
  logic [15:0] RAM_WDATA;
  logic [15:0] RAM_RDATA;

  lc3_mem_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_ACK(IF_ACK),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_IND(D_IND), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_ACK(D_ACK), .RDATA(RDATA), .BUSY(BUSY),
    .MAR_LE(MAR_LE), .MAR_CONTROL(MAR_CONTROL), .Y(Y),
    .RAM_WE(RAM_WE), .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA)
  );

  always #5 CLK = ~CLK;

  // MAR + single-port RAM; pk_* is a backdoor write used to preload contents.
  logic [15:0] mem [0:65535];
  logic [15:0] mar = '0;
  logic        pk_en = 1'b0;
  logic [15:0] pk_a = '0;
  logic [15:0] pk_d = '0;
  assign RAM_RDATA = mem[mar];

  always @(posedge CLK) begin
    if (RAM_WE) mem[mar] <= RAM_WDATA;
    if (pk_en) mem[pk_a] <= pk_d;
    if (MAR_LE) mar <= MAR_CONTROL ? RAM_RDATA : Y;
  end

  logic [15:0] ref_mem [0:65535];
  bit          last_was_d = 1'b0;
  int          checks = 0;
  int          errors = 0;

  int          d_lat, i_lat;
  logic [15:0] d_rd, i_rd;
  logic        tr_le [16];
  logic        tr_we [16];
  logic        tr_mc [16];
  logic [15:0] tr_y  [16];

  function automatic bit d_wins_collision();
`ifdef ARB_RR_EN
    return !last_was_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    pk_en = 1'b1; pk_a = a; pk_d = d;
    @(posedge CLK); #2;
    pk_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Raises the requested REQs, drops each one on the edge its ACK is seen, records latency and a trace.
  task automatic drive(input bit use_if, input bit use_d, input logic we, input logic ind,
                       input logic [15:0] iaddr, input logic [15:0] daddr, input logic [15:0] wdata);
    bit dd, ii;
    d_lat = -1; i_lat = -1; d_rd = 'x; i_rd = 'x;
    D_WE = we; D_IND = ind; D_ADDR = daddr; D_WDATA = wdata; IF_ADDR = iaddr;
    D_REQ = use_d; IF_REQ = use_if;
    #1;
    for (int k = 0; k < 16; k++) begin
      tr_le[k] = MAR_LE; tr_we[k] = RAM_WE; tr_mc[k] = MAR_CONTROL; tr_y[k] = Y;
      dd = D_ACK; ii = IF_ACK;
      if (dd && d_lat < 0) begin d_lat = k; d_rd = RDATA; end
      if (ii && i_lat < 0) begin i_lat = k; i_rd = RDATA; end
      @(posedge CLK); #1;
      if (dd) D_REQ = 1'b0;
      if (ii) IF_REQ = 1'b0;
      #1;
      if (!D_REQ && !IF_REQ) break;
    end
    D_REQ = 1'b0; IF_REQ = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #2 RESET = 1'b0;
    #1;
    checks++; if (BUSY !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b exp 0", BUSY); end
    checks++; if (IF_ACK !== 1'b0)  begin errors++; $display("FAIL reset_if_ack: got %b exp 0", IF_ACK); end
    checks++; if (D_ACK !== 1'b0)   begin errors++; $display("FAIL reset_d_ack: got %b exp 0", D_ACK); end
    checks++; if (RDATA !== 16'h0)  begin errors++; $display("FAIL reset_rdata: got %h exp 0000", RDATA); end
    checks++; if (MAR_LE !== 1'b0)  begin errors++; $display("FAIL reset_mar_le: got %b exp 0", MAR_LE); end
    checks++; if (RAM_WE !== 1'b0)  begin errors++; $display("FAIL reset_ram_we: got %b exp 0", RAM_WE); end
    last_was_d = 1'b0;
  endtask

  task automatic test_store();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h3000, 16'hBEEF);
    ref_mem[16'h3000] = 16'hBEEF; last_was_d = 1'b1;
    checks++; if (tr_le[0] !== 1'b1)    begin errors++; $display("FAIL store_mar_le: got %b exp 1", tr_le[0]); end
    checks++; if (tr_y[0] !== 16'h3000) begin errors++; $display("FAIL store_y: got %h exp 3000", tr_y[0]); end
    checks++; if (tr_we[0] !== 1'b0)    begin errors++; $display("FAIL store_we_idle: got %b exp 0", tr_we[0]); end
    checks++; if (tr_we[1] !== 1'b1)    begin errors++; $display("FAIL store_we_access: got %b exp 1", tr_we[1]); end
    checks++; if (d_lat !== 2)          begin errors++; $display("FAIL store_latency: got %0d exp 2", d_lat); end
    checks++; if (mem[16'h3000] !== 16'hBEEF) begin errors++; $display("FAIL store_mem: got %h exp beef", mem[16'h3000]); end
  endtask

  task automatic test_fetch();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0, 16'h0);
    last_was_d = 1'b0;
    checks++; if (i_lat !== 2)       begin errors++; $display("FAIL fetch_latency: got %0d exp 2", i_lat); end
    checks++; if (i_rd !== 16'hBEEF) begin errors++; $display("FAIL fetch_rdata: got %h exp beef", i_rd); end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h3001, 16'h1111);
    ref_mem[16'h3001] = 16'h1111; last_was_d = 1'b1;
    checks++; if (RDATA !== 16'hBEEF) begin errors++; $display("FAIL fetch_rdata_hold: got %h exp beef", RDATA); end
  endtask

  task automatic test_indirect();
    poke(16'h4000, 16'h3010);
    poke(16'h3010, 16'h1234);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h4000, 16'h0);
    last_was_d = 1'b1;
    checks++; if (tr_mc[0] !== 1'b0) begin errors++; $display("FAIL ldi_mc_idle: got %b exp 0", tr_mc[0]); end
    checks++; if (tr_mc[1] !== 1'b1 || tr_le[1] !== 1'b1)
      begin errors++; $display("FAIL ldi_ind_strobes: got mc=%b le=%b exp 1 1", tr_mc[1], tr_le[1]); end
    checks++; if (d_lat !== 3)       begin errors++; $display("FAIL ldi_latency: got %0d exp 3", d_lat); end
    checks++; if (d_rd !== 16'h1234) begin errors++; $display("FAIL ldi_rdata: got %h exp 1234", d_rd); end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0, 16'h4000, 16'h5555);
    ref_mem[16'h3010] = 16'h5555;
    checks++; if (d_lat !== 3) begin errors++; $display("FAIL sti_latency: got %0d exp 3", d_lat); end
    checks++; if (mem[16'h3010] !== 16'h5555) begin errors++; $display("FAIL sti_target: got %h exp 5555", mem[16'h3010]); end
    checks++; if (mem[16'h4000] !== 16'h3010) begin errors++; $display("FAIL sti_pointer: got %h exp 3010", mem[16'h4000]); end
  endtask

  task automatic test_collision();
    bit df;
    int ed, ei;
    for (int n = 0; n < 2; n++) begin
      df = d_wins_collision();
      ed = df ? 2 : 5;
      ei = df ? 5 : 2;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h4000, 16'h3010, 16'h0);
      last_was_d = !df;
      checks++; if (d_lat !== ed) begin errors++; $display("FAIL collide%0d_d_lat: got %0d exp %0d", n, d_lat, ed); end
      checks++; if (i_lat !== ei) begin errors++; $display("FAIL collide%0d_if_lat: got %0d exp %0d", n, i_lat, ei); end
      checks++; if (d_rd !== ref_mem[16'h3010]) begin errors++; $display("FAIL collide%0d_d_rdata: got %h exp %h", n, d_rd, ref_mem[16'h3010]); end
      checks++; if (i_rd !== ref_mem[16'h4000]) begin errors++; $display("FAIL collide%0d_if_rdata: got %h exp %h", n, i_rd, ref_mem[16'h4000]); end
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    poke(16'h5000, 16'hAAAA);
    D_WE = 1'b1; D_IND = 1'b0; D_ADDR = 16'h5000; D_WDATA = 16'h7777; D_REQ = 1'b1;
    @(posedge CLK); #1;
    checks++; if (RAM_WE !== 1'b1) begin errors++; $display("FAIL abort_we_before: got %b exp 1", RAM_WE); end
    #2 RESET = 1'b1;
    #1;
    checks++; if (RAM_WE !== 1'b0) begin errors++; $display("FAIL abort_we_drop: got %b exp 0", RAM_WE); end
    checks++; if (BUSY !== 1'b0)   begin errors++; $display("FAIL abort_busy: got %b exp 0", BUSY); end
    D_REQ = 1'b0;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      if (k == 0) RESET = 1'b0;
      #1;
      if (D_ACK || IF_ACK) acks++;
    end
    last_was_d = 1'b0;
    checks++; if (acks !== 0) begin errors++; $display("FAIL abort_no_ack: got %0d acks exp 0", acks); end
    checks++; if (mem[16'h5000] !== 16'hAAAA) begin errors++; $display("FAIL abort_mem: got %h exp aaaa", mem[16'h5000]); end
  endtask

  task automatic test_random();
    int mode, dl, ed, ei;
    bit we, ind, df, use_d, use_if;
    logic [15:0] da, ia, wd, tgt, exp_d, exp_i;
    for (int i = 0; i < 64; i++) poke(WIN | 16'(i), WIN | 16'($urandom_range(0, 63)));
    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 2);
      we = 1'($urandom); ind = 1'($urandom);
      da = WIN | 16'($urandom_range(0, 63));
      ia = WIN | 16'($urandom_range(0, 63));
      wd = WIN | 16'($urandom_range(0, 63));
      use_d = (mode != 1); use_if = (mode != 0);
      df = (mode == 2) ? d_wins_collision() : use_d;
      dl = ind ? 3 : 2;
      ed = -1; ei = -1; exp_d = 'x; exp_i = 'x;
      if (mode == 0) ed = dl;
      else if (mode == 1) ei = 2;
      else if (df) begin ed = dl; ei = dl + 3; end
      else begin ei = 2; ed = dl + 3; end
      // Reference effects in grant order.
      if (use_if && !df) exp_i = ref_mem[ia];
      if (use_d) begin
        tgt = ind ? ref_mem[da] : da;
        if (we) ref_mem[tgt] = wd; else exp_d = ref_mem[tgt];
      end
      if (use_if && df) exp_i = ref_mem[ia];
      drive(use_if, use_d, we, ind, ia, da, wd);
      last_was_d = (mode == 2) ? !df : use_d;
      if (use_d) begin
        checks++; if (d_lat !== ed) begin errors++; $display("FAIL rnd%0d_d_lat: got %0d exp %0d", n, d_lat, ed); end
        if (!we) begin
          checks++; if (d_rd !== exp_d) begin errors++; $display("FAIL rnd%0d_d_rdata: got %h exp %h", n, d_rd, exp_d); end
        end
      end
      if (use_if) begin
        checks++; if (i_lat !== ei)  begin errors++; $display("FAIL rnd%0d_if_lat: got %0d exp %0d", n, i_lat, ei); end
        checks++; if (i_rd !== exp_i) begin errors++; $display("FAIL rnd%0d_if_rdata: got %h exp %h", n, i_rd, exp_i); end
      end
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mem[WIN | 16'(i)] !== ref_mem[WIN | 16'(i)]) begin
        errors++; $display("FAIL rnd_mem[%h]: got %h exp %h", WIN | 16'(i), mem[WIN | 16'(i)], ref_mem[WIN | 16'(i)]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_fetch();
    test_indirect();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
